// File: rtl/frost32_mem_access_arbiter.sv
// Frost32 memory-port arbiter with sized byte-lane steering and zero-extension.
// Define FROST32_MEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module frost32_mem_access_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHANNELS-1:0]        ch_req,
    output logic [NUM_CHANNELS-1:0]        ch_ready,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CHANNELS-1:0]        ch_we,
    input  logic [NUM_CHANNELS*2-1:0]      ch_size,
    input  logic [NUM_CHANNELS*32-1:0]     ch_wdata,
    output logic [NUM_CHANNELS-1:0]        ch_resp,
    output logic [31:0]                    resp_rdata,
    output logic                           resp_err,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH/8-1:0]        mem_byte_en,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic                           mem_wait
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [1:0] Dias32  = 2'd0;
    localparam logic [1:0] Dias16  = 2'd1;
    localparam logic [1:0] Dias8   = 2'd2;
    localparam logic [1:0] DiasBad = 2'd3;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_t;

    state_t state_q, state_d;

    logic                  found;
    logic                  accept;
    logic [CH_W-1:0]       win;
    logic [CH_W-1:0]       ch_q;
    logic [1:0]            size_q;
    logic [LANE_W-1:0]     lane_q;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic                  sel_we;
    logic [31:0]           sel_wdata;
    logic                  sel_err;
    logic [LANE_W-1:0]     sel_lane;
    logic [BE_W-1:0]       be_base;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [31:0]           rd_word;
    logic [31:0]           rd_ext;

`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
    logic [CH_W-1:0]           rr_ptr;
    logic [2*NUM_CHANNELS-1:0] req_rot;

    // Rotate the request vector so bit 0 is the channel at the pointer.
    always_comb begin
        int cand;
        req_rot = {ch_req, ch_req} >> rr_ptr;
        found   = 1'b0;
        win     = '0;
        cand    = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                cand  = int'(rr_ptr) + k;
                if (cand >= NUM_CHANNELS) begin
                    cand = cand - NUM_CHANNELS;
                end
                win = CH_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(win) == NUM_CHANNELS - 1) ? '0 : win + 1'b1;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!found && ch_req[k]) begin
                found = 1'b1;
                win   = CH_W'(k);
            end
        end
    end
`endif

    always_comb begin
        sel_addr  = ch_addr[ADDR_WIDTH-1:0];
        sel_size  = ch_size[1:0];
        sel_we    = ch_we[0];
        sel_wdata = ch_wdata[31:0];
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (CH_W'(k) == win) begin
                sel_addr  = ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_size  = ch_size[k*2 +: 2];
                sel_we    = ch_we[k];
                sel_wdata = ch_wdata[k*32 +: 32];
            end
        end
    end

    assign accept   = (state_q == StIdle) && found;
    assign sel_lane = sel_addr[LANE_W-1:0];
    assign sel_err  = (sel_size == DiasBad)
                   || (sel_size == Dias32 && sel_addr[1:0] != 2'b00)
                   || (sel_size == Dias16 && sel_addr[0]);

    always_comb begin
        be_base   = BE_W'(1'b1);
        wdata_rep = {BE_W{sel_wdata[7:0]}};
        unique case (sel_size)
            Dias32: begin
                be_base   = BE_W'(4'hF);
                wdata_rep = {(DATA_WIDTH/32){sel_wdata}};
            end
            Dias16: begin
                be_base   = BE_W'(2'h3);
                wdata_rep = {(DATA_WIDTH/16){sel_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shift = mem_rdata >> {lane_q, 3'b000};
    assign rd_word  = rd_shift[31:0];

    always_comb begin
        rd_ext = {24'h0, rd_word[7:0]};
        unique case (size_q)
            Dias32:  rd_ext = rd_word;
            Dias16:  rd_ext = {16'h0, rd_word[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_ready = '0;
        ch_resp  = '0;
        mem_req  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    ch_ready = NUM_CHANNELS'(1) << win;
                    state_d  = sel_err ? StResp : StBus;
                end
            end
            StBus: begin
                mem_req = 1'b1;
                if (!mem_wait) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                ch_resp = NUM_CHANNELS'(1) << ch_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            size_q      <= '0;
            lane_q      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_byte_en <= '0;
            mem_wdata   <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else if (accept) begin
            ch_q        <= win;
            size_q      <= sel_size;
            lane_q      <= sel_lane;
            mem_we      <= sel_we;
            mem_addr    <= sel_addr & ~ADDR_WIDTH'(BE_W - 1);
            mem_byte_en <= be_base << sel_lane;
            mem_wdata   <= wdata_rep;
            resp_rdata  <= '0;
            resp_err    <= sel_err;
        end else if (state_q == StBus && !mem_wait && !mem_we) begin
            resp_rdata  <= rd_ext;
        end
    end

endmodule

// File: tb/tb_frost32_mem_access_arbiter.sv
// Scoreboard bench for frost32_mem_access_arbiter: 32-bit two-channel
// instance plus a 64-bit instance for wide-bus lane steering.
module tb_frost32_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [1:0]  ch_req, ch_ready, ch_we, ch_resp;
    logic [63:0] ch_addr;
    logic [3:0]  ch_size;
    logic [63:0] ch_wdata;
    logic [31:0] resp_rdata;
    logic        resp_err, mem_req, mem_we, mem_wait;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_en;

    logic [1:0]  w_ch_req, w_ch_ready, w_ch_we, w_ch_resp;
    logic [63:0] w_ch_addr;
    logic [3:0]  w_ch_size;
    logic [63:0] w_ch_wdata;
    logic [31:0] w_resp_rdata;
    logic        w_resp_err, w_mem_req, w_mem_we, w_mem_wait;
    logic [31:0] w_mem_addr;
    logic [63:0] w_mem_wdata, w_mem_rdata;
    logic [7:0]  w_mem_byte_en;

    frost32_mem_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req(ch_req), .ch_ready(ch_ready), .ch_addr(ch_addr),
        .ch_we(ch_we), .ch_size(ch_size), .ch_wdata(ch_wdata),
        .ch_resp(ch_resp), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    frost32_mem_access_arbiter #(.DATA_WIDTH(64)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .ch_req(w_ch_req), .ch_ready(w_ch_ready), .ch_addr(w_ch_addr),
        .ch_we(w_ch_we), .ch_size(w_ch_size), .ch_wdata(w_ch_wdata),
        .ch_resp(w_ch_resp), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_byte_en(w_mem_byte_en), .mem_wdata(w_mem_wdata),
        .mem_rdata(w_mem_rdata), .mem_wait(w_mem_wait)
    );

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ch_resp != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: ch_resp=%b rdata=%h err=%b, required no response",
                         ch_resp, resp_rdata, resp_err);
            end else begin
                sb_e = exp_q.pop_front();
                if (ch_resp !== (2'b01 << sb_e.ch) || resp_rdata !== sb_e.rdata
                    || resp_err !== sb_e.err) begin
                    errors++;
                    $display("FAIL sb_resp: ch_resp=%b rdata=%h err=%b, required ch=%0d rdata=%h err=%b",
                             ch_resp, resp_rdata, resp_err, sb_e.ch, sb_e.rdata, sb_e.err);
                end
            end
        end
    end

    task automatic set_req(input int ch, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        ch_we[ch]           = we;
        ch_size[ch*2 +: 2]  = sz;
        ch_addr[ch*32 +: 32] = addr;
        ch_wdata[ch*32 +: 32] = wd;
        ch_req[ch]          = 1'b1;
    endtask

    task automatic wait_accept(output int ch, output logic [1:0] rdy, output int at);
        ch = -1;
        rdy = 2'b00;
        at = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ch_ready != 2'b00) begin
                rdy = ch_ready;
                ch = ch_ready[1] ? 1 : 0;
                @(posedge clk);
                #1;
                at = cyc;
                return;
            end
            @(posedge clk);
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: ch_ready=%b, required nonzero within 20 cycles", ch_ready);
    endtask

    task automatic run_bus(input int waits, output int nreq, output int lat,
                           output logic [1:0] resp);
        nreq = 0;
        lat = 1;
        resp = 2'b00;
        for (int i = 0; i < 30; i++) begin
            if (mem_req) nreq++;
            mem_wait = (nreq <= waits) ? 1'b1 : 1'b0;
            if (ch_resp != 2'b00) begin
                resp = ch_resp;
                mem_wait = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        mem_wait = 1'b0;
        checks++;
        errors++;
        $display("FAIL resp_timeout: no ch_resp within 30 cycles, required a response");
    endtask

    task automatic test_reset;
        checks++;
        if (ch_ready !== 2'b00 || ch_resp !== 2'b00 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b resp=%b req=%b, required all 0",
                     ch_ready, ch_resp, mem_req);
        end
        checks++;
        if ({mem_we, mem_addr, mem_byte_en, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: we=%b addr=%h be=%b wdata=%h, required all 0",
                     mem_we, mem_addr, mem_byte_en, mem_wdata);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: rdata=%h err=%b, required 0", resp_rdata, resp_err);
        end
        checks++;
        if (w_mem_req !== 1'b0 || w_mem_byte_en !== 8'h0 || w_mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_wide: req=%b be=%h wdata=%h, required 0",
                     w_mem_req, w_mem_byte_en, w_mem_wdata);
        end
    endtask

    task automatic test_reads;
        int          chs[4]   = '{0, 1, 0, 1};
        logic [1:0]  szs[4]   = '{2'd2, 2'd1, 2'd0, 2'd2};
        logic [31:0] addrs[4] = '{32'h103, 32'h12, 32'h40, 32'h1};
        logic [3:0]  bes[4]   = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
        logic [31:0] maddr[4] = '{32'h100, 32'h10, 32'h40, 32'h0};
        logic [31:0] rds[4]   = '{32'hAA, 32'hAABB, 32'hAABBCCDD, 32'hCC};
        int g, at, nreq, lat;
        logic [1:0] rdy, resp;
        mem_rdata = 32'hAABBCCDD;
        for (int t = 0; t < 4; t++) begin
            set_req(chs[t], 1'b0, szs[t], addrs[t], 32'h0);
            wait_accept(g, rdy, at);
            ch_req = 2'b00;
            checks++;
            if (g != chs[t] || mem_req !== 1'b1 || mem_we !== 1'b0
                || mem_byte_en !== bes[t] || mem_addr !== maddr[t]) begin
                errors++;
                $display("FAIL read_bus[%0d]: g=%0d req=%b we=%b be=%b addr=%h, required g=%0d req=1 we=0 be=%b addr=%h",
                         t, g, mem_req, mem_we, mem_byte_en, mem_addr, chs[t], bes[t], maddr[t]);
            end
            exp_q.push_back('{chs[t], rds[t], 1'b0});
            run_bus(0, nreq, lat, resp);
            checks++;
            if (lat != 2 || nreq != 1 || resp !== (2'b01 << chs[t])) begin
                errors++;
                $display("FAIL read_lat[%0d]: lat=%0d nreq=%0d resp=%b, required lat=2 nreq=1 resp=%b",
                         t, lat, nreq, resp, 2'b01 << chs[t]);
            end
        end
    endtask

    task automatic test_write16;
        int g, at, nreq, lat;
        logic [1:0] rdy, resp;
        mem_rdata = 32'hAABBCCDD;
        set_req(1, 1'b1, 2'd1, 32'h22, 32'h1234);
        wait_accept(g, rdy, at);
        ch_req = 2'b00;
        checks++;
        if (g != 1 || mem_wdata !== 32'h12341234 || mem_byte_en !== 4'b1100
            || mem_we !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL write_bus: g=%0d wdata=%h be=%b we=%b addr=%h, required 1 12341234 1100 1 00000020",
                     g, mem_wdata, mem_byte_en, mem_we, mem_addr);
        end
        exp_q.push_back('{1, 32'h0, 1'b0});
        run_bus(3, nreq, lat, resp);
        checks++;
        if (nreq != 4 || lat != 5 || resp !== 2'b10) begin
            errors++;
            $display("FAIL write_wait: nreq=%0d lat=%0d resp=%b, required 4 5 10", nreq, lat, resp);
        end
    endtask

    task automatic test_errors;
        int          chs[3]   = '{0, 1, 1};
        logic [1:0]  szs[3]   = '{2'd0, 2'd3, 2'd1};
        logic [31:0] addrs[3] = '{32'h6, 32'h0, 32'h3};
        int g, at, nreq, lat;
        logic [1:0] rdy, resp;
        for (int t = 0; t < 3; t++) begin
            set_req(chs[t], 1'b0, szs[t], addrs[t], 32'hFFFF_FFFF);
            wait_accept(g, rdy, at);
            ch_req = 2'b00;
            exp_q.push_back('{chs[t], 32'h0, 1'b1});
            run_bus(0, nreq, lat, resp);
            checks++;
            if (g != chs[t] || nreq != 0 || lat != 1 || resp !== (2'b01 << chs[t])) begin
                errors++;
                $display("FAIL err_path[%0d]: g=%0d nreq=%0d lat=%0d resp=%b, required g=%0d nreq=0 lat=1",
                         t, g, nreq, lat, resp, chs[t]);
            end
        end
    endtask

    task automatic test_back_to_back;
`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
        int exp_g[4] = '{0, 1, 0, 1};
`else
        int exp_g[4] = '{0, 0, 0, 0};
`endif
        int g, at, prev_at, nreq, lat;
        logic [1:0] rdy, resp;
        prev_at = 0;
        mem_rdata = 32'hCAFEF00D;
        set_req(0, 1'b0, 2'd0, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h4, 32'h0);
        for (int t = 0; t < 4; t++) begin
            wait_accept(g, rdy, at);
            checks++;
            if (g != exp_g[t] || $countones(rdy) != 1) begin
                errors++;
                $display("FAIL grant[%0d]: g=%0d ready=%b, required g=%0d one-hot",
                         t, g, rdy, exp_g[t]);
            end
            if (t > 0) begin
                checks++;
                if (at - prev_at != 3) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: gap=%0d, required 3", t, at - prev_at);
                end
            end
            prev_at = at;
            exp_q.push_back('{g, 32'hCAFEF00D, 1'b0});
            run_bus(0, nreq, lat, resp);
        end
        ch_req = 2'b00;
    endtask

    task automatic test_reset_abort;
        int g, at, nreq, lat;
        logic [1:0] rdy, resp;
        set_req(0, 1'b0, 2'd0, 32'h8, 32'h0);
        wait_accept(g, rdy, at);
        ch_req = 2'b00;
        mem_wait = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: mem_req=%b, required 1", mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ch_resp !== 2'b00) begin
            errors++;
            $display("FAIL abort_async: mem_req=%b ch_resp=%b, required 0 0", mem_req, ch_resp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_wait = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (ch_resp !== 2'b00 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: ch_resp=%b mem_req=%b, required 0 0", ch_resp, mem_req);
            end
        end
        mem_rdata = 32'hAABBCCDD;
        set_req(1, 1'b0, 2'd2, 32'h101, 32'h0);
        wait_accept(g, rdy, at);
        ch_req = 2'b00;
        checks++;
        if (g != 1 || mem_byte_en !== 4'b0010 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL abort_after: g=%0d be=%b addr=%h, required 1 0010 00000100",
                     g, mem_byte_en, mem_addr);
        end
        exp_q.push_back('{1, 32'hCC, 1'b0});
        run_bus(0, nreq, lat, resp);
        checks++;
        if (lat != 2 || resp !== 2'b10) begin
            errors++;
            $display("FAIL abort_after_lat: lat=%0d resp=%b, required 2 10", lat, resp);
        end
    endtask

    task automatic test_wide64;
        w_mem_rdata = 64'h11223344_55667788;
        w_ch_we[0] = 1'b0;
        w_ch_size[1:0] = 2'd0;
        w_ch_addr[31:0] = 32'h4;
        w_ch_req[0] = 1'b1;
        @(posedge clk);
        #1;
        w_ch_req = 2'b00;
        checks++;
        if (w_mem_req !== 1'b1 || w_mem_byte_en !== 8'hF0 || w_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wide_rd_bus: req=%b be=%h addr=%h, required 1 f0 00000000",
                     w_mem_req, w_mem_byte_en, w_mem_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (w_ch_resp !== 2'b01 || w_resp_rdata !== 32'h11223344 || w_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL wide_rd_resp: resp=%b rdata=%h err=%b, required 01 11223344 0",
                     w_ch_resp, w_resp_rdata, w_resp_err);
        end
        w_ch_we[1] = 1'b1;
        w_ch_size[3:2] = 2'd2;
        w_ch_addr[63:32] = 32'hD;
        w_ch_wdata[63:32] = 32'h5A;
        w_ch_req[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        w_ch_req = 2'b00;
        checks++;
        if (w_mem_req !== 1'b1 || w_mem_we !== 1'b1 || w_mem_byte_en !== 8'h20
            || w_mem_addr !== 32'h8 || w_mem_wdata !== 64'h5A5A5A5A_5A5A5A5A) begin
            errors++;
            $display("FAIL wide_wr_bus: req=%b we=%b be=%h addr=%h wdata=%h, required 1 1 20 00000008 5a5a5a5a5a5a5a5a",
                     w_mem_req, w_mem_we, w_mem_byte_en, w_mem_addr, w_mem_wdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (w_ch_resp !== 2'b10 || w_resp_rdata !== 32'h0 || w_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL wide_wr_resp: resp=%b rdata=%h err=%b, required 10 00000000 0",
                     w_ch_resp, w_resp_rdata, w_resp_err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_size = '0; ch_wdata = '0;
        mem_rdata = '0; mem_wait = 1'b0;
        w_ch_req = '0; w_ch_we = '0; w_ch_addr = '0; w_ch_size = '0; w_ch_wdata = '0;
        w_mem_rdata = '0; w_mem_wait = 1'b0;
        #2;
        test_reset();
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reads();
        test_write16();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_wide64();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frost32_mem_access_arbiter.md
# frost32_mem_access_arbiter

Parametrised memory-access arbiter and size-aware bus adapter for the Frost32 memory port. It accepts sized read/write requests from `NUM_CHANNELS` requesters (e.g. fetch, load/store, debug), serialises them onto one memory bus with a `mem_wait` stall handshake, and generates byte enables. It also performs byte-lane steering and zero-extension for 32/16/8-bit accesses on a configurable data width. It sits between the CPU pipeline and the external memory/interconnect.

## Interface
- `DATA_WIDTH`, 32, bus data width; power of two, ≥32.
- `ADDR_WIDTH`, 32, byte address width.
- `NUM_CHANNELS`, 2, requester count, 1..8; channel 0 is lowest index.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ch_req`  in  NUM_CHANNELS  per-channel request valid.
- `ch_ready`  out  NUM_CHANNELS  one-hot request-accepted pulse.
- `ch_addr`  in  NUM_CHANNELS*ADDR_WIDTH  flattened byte addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `ch_we`  in  NUM_CHANNELS  access type: 0 = DiatRead, 1 = DiatWrite.
- `ch_size`  in  NUM_CHANNELS*2  access size: 0 = Dias32, 1 = Dias16, 2 = Dias8, 3 = DiasBad.
- `ch_wdata`  in  NUM_CHANNELS*32  write data, right-justified.
- `ch_resp`  out  NUM_CHANNELS  one-hot response-valid pulse.
- `resp_rdata`  out  32  read data, zero-extended; valid with `ch_resp`.
- `resp_err`  out  1  error flag; valid with `ch_resp`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  ADDR_WIDTH  bus address, aligned down to DATA_WIDTH/8 bytes.
- `mem_byte_en`  out  DATA_WIDTH/8  byte enables.
- `mem_wdata`  out  DATA_WIDTH  lane-steered write data.
- `mem_rdata`  in  DATA_WIDTH  bus read data.
- `mem_wait`  in  1  1 = memory not done this cycle (`wait_for_mem`).

## Operation
- FSM states: StIdle, StBus, StResp.
- StIdle: if any `ch_req`, select the winner, pulse `ch_ready[winner]` combinationally, and latch addr/we/size/wdata and channel index.
  - Valid request: go to StBus.
  - Error request (size 3, or misaligned: Dias32 needs addr[1:0]=0, Dias16 needs addr[0]=0): go to StResp with err=1; no bus cycle.
- StBus: `mem_req`=1, address/controls held stable.
  - `mem_wait`=1: stay in StBus.
  - `mem_wait`=0: capture lane-extracted read data and go to StResp.
- StResp: `ch_resp[ch]`=1 for one cycle with `resp_rdata`/`resp_err`, then go to StIdle.
- Lane index is `addr[log2(DATA_WIDTH/8)-1:0]`.
  - Byte enables: Dias8 sets 1 bit, Dias16 sets 2, Dias32 sets 4, at that lane.
  - `mem_wdata` replicates the sized datum into every lane group.
  - Reads extract the addressed lane and zero-extend to 32 bits.
  - For error responses, and on writes, `resp_rdata`=0.
- Requesters hold `ch_req` and payload until `ch_ready`. Dropping a request before `ch_ready` is legal; it is simply not served.
- At most one transaction is outstanding.

## Timing
- Reset values: `ch_ready`=0, `ch_resp`=0, `resp_rdata`=0, `resp_err`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_byte_en`=0, `mem_wdata`=0; state StIdle; round-robin pointer = 0.
- Accept in cycle T. `mem_req` is high from T+1. If `mem_wait`=0 at T+1, `ch_resp` fires at T+2 (minimum latency 2). Each `mem_wait` cycle adds 1.
- Error path: accept at T, `ch_resp`/`resp_err` at T+1.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- `rst_n` asserted mid-StBus: `mem_req` drops immediately (asynchronous), and no response is generated for the aborted transaction.
- `ch_req` arriving during StBus/StResp waits; it is arbitrated on return to StIdle.

## Configuration
- `FROST32_MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. The pointer advances to (winner+1) mod NUM_CHANNELS after each accept, and the search starts at the pointer.
- Undefined: fixed priority, lowest channel index wins; no pointer register.

## Test plan
- Single read, NUM_CHANNELS=2, ch0 Dias8 addr 0x103, mem_rdata=0xAABBCCDD, `mem_wait`=0 → `mem_byte_en`=4'b1000, `mem_addr`=0x100, `resp_rdata`=0x000000AA, `ch_resp`=2'b01 two cycles after accept.
- Write, ch1 Dias16 addr 0x22, wdata 0x1234, 3 `mem_wait` cycles → `mem_wdata`=0x12341234, `mem_byte_en`=4'b1100, `mem_req` high 4 cycles, `ch_resp`=2'b10, `resp_err`=0.
- Misaligned Dias32 at 0x6, and size 3 at 0x0 → `mem_req` never asserts, `resp_err`=1 one cycle after accept, `resp_rdata`=0.
- Both channels requesting continuously for 4 transactions → with macro, grants 0,1,0,1; without macro, grants 0,0,0,0.
- DATA_WIDTH=64, Dias32 read at 0x04, mem_rdata=0x11223344_55667788 → `mem_byte_en`=8'hF0, `resp_rdata`=0x11223344.
- `rst_n` low during StBus with `mem_wait`=1 → `mem_req`=0 without a clock edge, no `ch_resp`; after release, a new request completes normally.
